// File: rtl/sd_sector_packer_if.sv
// Word stream leaving the sector packer: valid/ready handshake with a last-word marker.
// The packer drives the master side; the downstream consumer uses the slave side.
interface sd_sector_packer_if;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/sd_sector_packer.sv
// Packs the SD reader byte stream into little-endian 32-bit words behind a small FIFO, with
// sticky error flags. Optional macro SECTOR_SUM_EN builds the per-sector 16-bit byte sum.
module sd_sector_packer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       outreq,
  input  logic [8:0]                 outaddr,
  input  logic [7:0]                 outbyte,
  input  logic                       rdone,
  sd_sector_packer_if.master         m_if,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                       seq_err,
  output logic                       ovf_err,
  output logic                       short_err,
  input  logic                       clr_err,
  output logic                       sum_valid,
  output logic [15:0]                sector_sum
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t      state_reg, state_next;
  logic [8:0]  exp_addr_reg, exp_addr_next;
  logic        rdone_d_reg;
  logic        rdone_rise;
  logic        rdone_exit;
  logic        short_hit;

  assign rdone_rise = rdone && !rdone_d_reg;
  assign rdone_exit = rdone_rise && (state_reg == COLLECT);

  // The byte of this cycle is applied first; a rdone rise then judges the updated index.
  always_comb begin
    state_next    = state_reg;
    exp_addr_next = exp_addr_reg;
    short_hit     = 1'b0;
    if (outreq) begin
      exp_addr_next = outaddr + 9'd1;
      state_next    = (outaddr == 9'd511) ? IDLE : COLLECT;
    end
    if (rdone_exit) begin
      state_next = IDLE;
      if (exp_addr_next != 9'd0) begin
        short_hit     = 1'b1;
        exp_addr_next = 9'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      exp_addr_reg <= 9'd0;
      rdone_d_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      exp_addr_reg <= exp_addr_next;
      rdone_d_reg  <= rdone;
    end
  end

  // Lanes 0..2 hold the earlier bytes of the word; byte 3 goes straight into the push.
  logic [23:0] lanes;
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    logic [7:0] lane_reg;
    always_ff @(posedge clk) begin
      if (rst || short_hit) begin
        lane_reg <= 8'd0;
      end else if (outreq && (outaddr[1:0] == 2'(gi))) begin
        lane_reg <= outbyte;
      end
    end
    assign lanes[gi*8 +: 8] = lane_reg;
  end

  logic        push_req, push, pop, full;
  logic [32:0] push_entry;
  logic [32:0] head;
  logic [32:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;

  assign push_req   = outreq && (outaddr[1:0] == 2'b11);
  assign push_entry = {(outaddr == 9'd511), outbyte, lanes};
  assign full       = (level_reg == DEPTH_LVL);
  assign pop        = (level_reg != '0) && m_if.m_ready;
  assign push       = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Head is masked while empty so the bus reads zero rather than stale storage.
  assign head         = mem[rd_ptr_reg];
  assign m_if.m_valid = (level_reg != '0);
  assign m_if.m_data  = m_if.m_valid ? head[31:0] : 32'd0;
  assign m_if.m_last  = m_if.m_valid && head[32];
  assign level        = level_reg;

  logic seq_err_reg, ovf_err_reg, short_err_reg;
  logic seq_set, ovf_set;

  assign seq_set = outreq && (outaddr != exp_addr_reg);
  assign ovf_set = push_req && !push;

  // A new error in the same cycle as clr_err keeps its flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_err_reg   <= 1'b0;
      ovf_err_reg   <= 1'b0;
      short_err_reg <= 1'b0;
    end else begin
      seq_err_reg   <= (seq_err_reg && !clr_err) || seq_set;
      ovf_err_reg   <= (ovf_err_reg && !clr_err) || ovf_set;
      short_err_reg <= (short_err_reg && !clr_err) || short_hit;
    end
  end

  assign seq_err   = seq_err_reg;
  assign ovf_err   = ovf_err_reg;
  assign short_err = short_err_reg;

`ifdef SECTOR_SUM_EN
  logic [15:0] acc_reg, acc_add, sum_reg;
  logic        sum_valid_reg;

  assign acc_add = ((outaddr == 9'd0) ? 16'd0 : acc_reg) + {8'd0, outbyte};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg       <= 16'd0;
      sum_reg       <= 16'd0;
      sum_valid_reg <= 1'b0;
    end else begin
      sum_valid_reg <= 1'b0;
      if (rdone_exit) begin
        acc_reg <= 16'd0;
      end else if (outreq) begin
        acc_reg <= acc_add;
      end
      if (outreq && (outaddr == 9'd511)) begin
        sum_reg       <= acc_add;
        sum_valid_reg <= 1'b1;
      end
    end
  end

  assign sum_valid  = sum_valid_reg;
  assign sector_sum = sum_reg;
`else
  assign sum_valid  = 1'b0;
  assign sector_sum = 16'd0;
`endif

endmodule
